// File: rtl/fifo_bank_scheduler.sv
// Round-robin read scheduler draining NUM_BANKS sync FIFO banks into one valid/ready stream.
// Define FIFO_SCHED_PRIO0_EN to make bank 0 strict priority with unbounded bursts.
module fifo_bank_scheduler #(
    parameter int NUM_BANKS = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4,
    localparam int BW       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sched_en,
    input  logic [NUM_BANKS-1:0]        bank_empty,
    input  logic [NUM_BANKS*DATA_W-1:0] bank_data,
    output logic [NUM_BANKS-1:0]        bank_rd_en,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [BW-1:0]               out_bank,
    output logic                        busy
);

    localparam int CW = $clog2(BURST_MAX + 1);

    // Handshake: a word transfers on any posedge where out_valid && out_ready;
    // out_valid never drops and out_data/out_bank never change until then.
    typedef enum logic [1:0] {IDLE, POP, CAPT, HOLD} state_t;

    state_t          state, state_nxt;
    logic [BW-1:0]   rr_ptr, grant, pick, ptr_nxt;
    logic            pick_vld;
    logic [CW-1:0]   burst_cnt;
    logic            burst_lim_ok, burst_cont;
    int              idx;

    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_BANKS;
            if (!pick_vld && !bank_empty[idx]) begin
                pick     = BW'(idx);
                pick_vld = 1'b1;
            end
        end
`ifdef FIFO_SCHED_PRIO0_EN
        if (!bank_empty[0]) begin
            pick     = '0;
            pick_vld = 1'b1;
        end
`endif
    end

    always_comb begin
`ifdef FIFO_SCHED_PRIO0_EN
        burst_lim_ok = (grant == '0) || (int'(burst_cnt) + 1 < BURST_MAX);
`else
        burst_lim_ok = (int'(burst_cnt) + 1 < BURST_MAX);
`endif
        burst_cont = burst_lim_ok && !bank_empty[grant] && sched_en;
        ptr_nxt    = (grant == BW'(NUM_BANKS - 1)) ? '0 : grant + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        bank_rd_en = '0;
        case (state)
            IDLE: if (sched_en && pick_vld) state_nxt = POP;
            POP: begin
                // Sole reader of every bank, so the granted bank is still non-empty here.
                bank_rd_en[grant] = 1'b1;
                state_nxt         = CAPT;
            end
            CAPT: state_nxt = HOLD;
            HOLD: if (out_ready) state_nxt = burst_cont ? POP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            grant     <= '0;
            burst_cnt <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_bank  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sched_en && pick_vld) begin
                        grant     <= pick;
                        burst_cnt <= '0;
                    end
                end
                CAPT: begin
                    // Bank data_out is registered, so the popped word appears one cycle after rd_en.
                    out_data  <= bank_data[int'(grant)*DATA_W +: DATA_W];
                    out_bank  <= grant;
                    out_valid <= 1'b1;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (burst_cnt != CW'(BURST_MAX)) burst_cnt <= burst_cnt + 1'b1;
                        if (!burst_cont) rr_ptr <= ptr_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_bank_scheduler.sv
// Self-checking bench for fifo_bank_scheduler: behavioural FIFO banks, transaction-level
// arbitration model feeding an expected queue, handshake monitor comparing delivered words.
module tb_fifo_bank_scheduler;

  localparam int NB = 4;
  localparam int DW = 8;
  localparam int BM = 4;
  localparam int BW = 2;

  logic             clk;
  logic             reset;
  logic             sched_en;
  logic [NB-1:0]    bank_empty;
  logic [NB*DW-1:0] bank_data;
  logic [NB-1:0]    bank_rd_en;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [BW-1:0]    out_bank;
  logic             busy;

  int tests_run = 0;
  int tests_failed = 0;
  int hs_cnt = 0;
  int rd_cnt = 0;
  int tb_rr = 0;

  logic [DW-1:0]    fifo_mem [NB][256];
  int               push_cnt [NB] = '{default: 0};
  int               pop_cnt  [NB] = '{default: 0};
  logic [DW-1:0]    fifo_dout [NB] = '{default: '0};
  logic [DW-1:0]    mdl_q [NB][$];
  logic [BW+DW-1:0] exp_q [$];

  fifo_bank_scheduler #(.NUM_BANKS(NB), .DATA_W(DW), .BURST_MAX(BM)) dut (
    .clk        (clk),
    .reset      (reset),
    .sched_en   (sched_en),
    .bank_empty (bank_empty),
    .bank_data  (bank_data),
    .bank_rd_en (bank_rd_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_bank   (out_bank),
    .busy       (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // behavioural banks with registered data_out
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      bank_empty[i] = (pop_cnt[i] >= push_cnt[i]);
      bank_data[i*DW +: DW] = fifo_dout[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (bank_rd_en[i]) begin
        fifo_dout[i] <= fifo_mem[i][pop_cnt[i] % 256];
        pop_cnt[i]   <= pop_cnt[i] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic load(input int b, input logic [DW-1:0] d);
    fifo_mem[b][push_cnt[b] % 256] = d;
    push_cnt[b] = push_cnt[b] + 1;
    mdl_q[b].push_back(d);
  endtask

  task automatic predict();
    int g;
    int lim;
    int n;
    while (1) begin
      g = -1;
      for (int k = 0; k < NB; k++) begin
        int id = (tb_rr + k) % NB;
        if (g < 0 && mdl_q[id].size() > 0) g = id;
      end
`ifdef FIFO_SCHED_PRIO0_EN
      if (mdl_q[0].size() > 0) g = 0;
`endif
      if (g < 0) break;
      lim = BM;
`ifdef FIFO_SCHED_PRIO0_EN
      if (g == 0) lim = 1 << 30;
`endif
      n = 0;
      while (n < lim && mdl_q[g].size() > 0) begin
        exp_q.push_back({BW'(g), mdl_q[g].pop_front()});
        n++;
      end
      tb_rr = (g + 1) % NB;
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || busy) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(tag, (c < budget), 1);
  endtask

  task automatic wait_rd(input string tag, input int budget);
    int c = 0;
    @(negedge clk);
    while (bank_rd_en == '0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(tag, (c < budget), 1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int c = 0;
    @(negedge clk);
    while (!out_valid && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(tag, (c < budget), 1);
  endtask

  // scoreboard monitor: compare every handshake, police rd_en legality
  always @(negedge clk) begin
    if (!reset) begin
      if (bank_rd_en != '0) begin
        rd_cnt++;
        check("rd_onehot", 32'($onehot(bank_rd_en)), 1);
        check("rd_nonempty", 32'(|(bank_rd_en & bank_empty)), 0);
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) check("extra_word", {out_bank, out_data}, 32'hFFFF_FFFF);
        else check("out_word", {out_bank, out_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int h0;
    int r0;
    logic [BW+DW-1:0] held;

    // reset state
    reset = 1'b1; sched_en = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", bank_rd_en, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_bank", out_bank, 0);
    check("rst_busy", busy, 0);
    drive_edge();
    load(1, 8'h3C);
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_no_rd", bank_rd_en, 0);
      check("rst_hold_busy", busy, 0);
    end
    predict();
    drive_edge();
    reset = 1'b0;
    drain("t1_drain", 50);

    // single word from bank 2, latency
    drive_edge();
    load(2, 8'hA5);
    predict();
    wait_rd("t2_wait_rd", 20);
    check("t2_rd_en", bank_rd_en, 4'b0100);
    @(negedge clk);
    check("t2_rd_one_cycle", bank_rd_en, 0);
    check("t2_capt_valid", out_valid, 0);
    @(negedge clk);
    check("t2_valid_lat", out_valid, 1);
    check("t2_data", out_data, 8'hA5);
    check("t2_bank", out_bank, 2);
    drain("t2_drain", 50);
    @(negedge clk);
    check("t2_hold_data", out_data, 8'hA5);
    check("t2_idle_valid", out_valid, 0);
    check("t2_idle_busy", busy, 0);

    // rr_ptr now 3: bank 3 precedes bank 0
    drive_edge();
    load(0, 8'h01);
    load(3, 8'h03);
    predict();
    drain("t2b_drain", 100);

    // fairness and wrap from a fresh reset
    drive_edge();
    reset = 1'b1;
    repeat (2) drive_edge();
    reset = 1'b0;
    tb_rr = 0;
    for (int i = 0; i < 8; i++)
      for (int b = 0; b < NB; b++) load(b, 8'($urandom_range(0, 255)));
    predict();
    drain("t3_drain", 400);

    // backpressure
    drive_edge();
    out_ready = 1'b0;
    h0 = hs_cnt;
    load(0, 8'h11);
    load(0, 8'h22);
    predict();
    wait_valid("t4_wait_valid", 20);
    held = exp_q[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_valid_stable", out_valid, 1);
      check("t4_word_stable", {out_bank, out_data}, held);
      check("t4_no_rd", bank_rd_en, 0);
    end
    drive_edge();
    out_ready = 1'b1;
    drain("t4_drain", 50);
    check("t4_hs_count", hs_cnt - h0, 2);

    // sched_en dropped during CAPT
    drive_edge();
    h0 = hs_cnt;
    r0 = rd_cnt;
    load(1, 8'h71);
    load(1, 8'h72);
    load(1, 8'h73);
    predict();
    wait_rd("t5_wait_rd", 20);
    drive_edge();
    sched_en = 1'b0;
    repeat (12) @(negedge clk);
    check("t5_one_word", hs_cnt - h0, 1);
    check("t5_one_pop", rd_cnt - r0, 1);
    check("t5_idle", busy, 0);
    drive_edge();
    sched_en = 1'b1;
    drain("t5_drain", 100);
    check("t5_all_words", hs_cnt - h0, 3);

    // priority bank 0 versus round-robin, rr_ptr set to 1 first
    drive_edge();
    load(0, 8'h5A);
    predict();
    drain("t6_pre_drain", 50);
    drive_edge();
    load(1, 8'hB0);
    load(1, 8'hB1);
    for (int i = 0; i < 6; i++) load(0, 8'(8'hC0 + i));
    predict();
    wait_valid("t6_wait_valid", 20);
`ifdef FIFO_SCHED_PRIO0_EN
    check("t6_first_bank", out_bank, 0);
`else
    check("t6_first_bank", out_bank, 1);
`endif
    drain("t6_drain", 200);

    check("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
